// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, response and data-memory signal bundle for mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem_waddr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               dmem_raddr, dmem_waddr, dmem_we, dmem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               dmem_raddr, dmem_waddr, dmem_we, dmem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/halfword/word load-store unit over a word-only data memory
module mem_access_unit #(
    parameter int DMEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

    state_t      state;
    state_t      state_nxt;

    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] addr_aligned;

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_extract = sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   load_extract = sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_word(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = old;
        if (size == 2'b00)
            w[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        merge_word = w;
    endfunction

    assign accept       = bus.req_valid && bus.req_ready;
    assign addr_aligned = {addr_q[31:2], 2'b00};

    // Rejected requests go straight to RESP and never reach the memory port.
    assign req_err = (bus.req_size == 2'b11)
                  || (bus.req_size == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                  || ({1'b0, bus.req_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            merge_q  <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= bus.req_we;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                err_q    <= req_err;
                rdata_q  <= 32'b0;
            end
            if (state == LOAD)
                rdata_q <= load_extract(bus.dmem_rdata, size_q, signed_q, addr_q[1:0]);
            if (state == RMW_RD)
                merge_q <= bus.dmem_rdata;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'b0;
        bus.resp_err   = 1'b0;
        bus.dmem_raddr = 32'b0;
        bus.dmem_waddr = 32'b0;
        bus.dmem_we    = 1'b0;
        bus.dmem_wdata = 32'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (!bus.req_we)
                        state_nxt = LOAD;
                    else if (bus.req_size == 2'b10)
                        state_nxt = WRITE;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                bus.dmem_raddr = addr_aligned;
                state_nxt      = RESP;
            end
            WRITE: begin
                bus.dmem_we    = 1'b1;
                bus.dmem_waddr = addr_aligned;
                bus.dmem_wdata = wdata_q;
                state_nxt      = RESP;
            end
            RMW_RD: begin
                bus.dmem_raddr = addr_aligned;
                state_nxt      = RMW_WR;
            end
            RMW_WR: begin
                bus.dmem_we    = 1'b1;
                bus.dmem_waddr = addr_aligned;
                bus.dmem_wdata = merge_word(merge_q, wdata_q, size_q, addr_q[1:0]);
                state_nxt      = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs go quiet the moment rst rises, so no write lands on an edge during reset.
        if (rst) begin
            bus.req_ready  = 1'b0;
            bus.resp_valid = 1'b0;
            bus.resp_rdata = 32'b0;
            bus.resp_err   = 1'b0;
            bus.dmem_raddr = 32'b0;
            bus.dmem_waddr = 32'b0;
            bus.dmem_we    = 1'b0;
            bus.dmem_wdata = 32'b0;
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int DMEM_WORDS = 256;

    logic clk;
    logic rst;

    mem_access_unit_if bus();

    mem_access_unit #(.DMEM_WORDS(DMEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [DMEM_WORDS];
    logic [31:0] ref_mem [DMEM_WORDS];

    assign bus.dmem_rdata = mem[bus.dmem_raddr[9:2]];

    always @(posedge clk)
        if (bus.dmem_we)
            mem[bus.dmem_waddr[9:2]] <= bus.dmem_wdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_rdata;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int size, input bit sgn);
        int unsigned word;
        int unsigned sh;
        int unsigned v;
        word = ref_mem[addr / 4];
        sh   = (addr % 4) * 8;
        if (size == 0) begin
            v = (word >> sh) & 255;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (word >> sh) & 65535;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int size, input logic [31:0] wdata);
        int unsigned mask;
        int unsigned sh;
        sh   = (addr % 4) * 8;
        mask = (size == 0) ? 255 : (size == 1) ? 65535 : 32'hFFFF_FFFF;
        ref_mem[addr / 4] = (ref_mem[addr / 4] & ~(mask << sh)) | ((wdata & mask) << sh);
    endtask

    task automatic run_req(input string tag, input bit we, input int size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit          exp_err;
        int          exp_lat;
        int          exp_wc;
        logic [31:0] exp_rdata;
        int          rc;
        int          wc;
        int          nwe;
        logic [31:0] rd;
        logic        re;

        exp_err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)
               || (addr >= DMEM_WORDS * 4);
        exp_lat = exp_err ? 1 : (!we ? 2 : (size == 2 ? 2 : 3));
        exp_wc  = (exp_err || !we) ? -1 : (size == 2 ? 1 : 2);
        exp_rdata = (exp_err || we) ? 32'b0 : model_load(addr, size, sgn);
        if (!exp_err && we) model_store(addr, size, wdata);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size[1:0];
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        check({tag, " ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);

        rc = -1; wc = -1; nwe = 0; rd = 'x; re = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.dmem_we) begin
                nwe++;
                wc = c;
                last_waddr = bus.dmem_waddr;
                last_wdata = bus.dmem_wdata;
            end
            if (bus.resp_valid) begin
                rc = c;
                rd = bus.resp_rdata;
                re = bus.resp_err;
                break;
            end
        end
        last_rdata = rd;

        check({tag, " latency"}, rc, exp_lat);
        check({tag, " err"}, {31'b0, re}, {31'b0, exp_err});
        check({tag, " rdata"}, rd, exp_rdata);
        check({tag, " writes"}, nwe, (exp_wc < 0) ? 0 : 1);
        if (exp_wc >= 0) begin
            check({tag, " write cycle"}, wc, exp_wc);
            check({tag, " waddr"}, last_waddr, addr & 32'hFFFF_FFFC);
            check({tag, " wdata"}, last_wdata, ref_mem[addr / 4]);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w1;
        int          sz;
        int          first_resp;
        int          acc_c;
        int          second_resp;
        logic [31:0] rd2;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'b0;
        bus.req_wdata  = 32'b0;

        repeat (3) @(negedge clk);
        check("rst ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst dmem_we", {31'b0, bus.dmem_we}, 32'd0);
        check("rst dmem_raddr", bus.dmem_raddr, 32'd0);
        check("rst dmem_waddr", bus.dmem_waddr, 32'd0);
        check("rst dmem_wdata", bus.dmem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) run_req("fill", 1'b1, 2, 1'b0, i * 4, $urandom);

        run_req("sw 0x10", 1'b1, 2, 1'b0, 32'h10, 32'hDEADBEEF);
        run_req("lw 0x10", 1'b0, 2, 1'b0, 32'h10, 32'h0);
        check("lw const", last_rdata, 32'hDEADBEEF);

        run_req("sw 0x10b", 1'b1, 2, 1'b0, 32'h10, 32'h80FF7F01);
        run_req("lb 0x13", 1'b0, 0, 1'b1, 32'h13, 32'h0);
        check("lb const", last_rdata, 32'hFFFFFF80);
        run_req("lbu 0x13", 1'b0, 0, 1'b0, 32'h13, 32'h0);
        check("lbu const", last_rdata, 32'h00000080);
        run_req("lh 0x12", 1'b0, 1, 1'b1, 32'h12, 32'h0);
        check("lh const", last_rdata, 32'hFFFF80FF);

        run_req("sw 0x20", 1'b1, 2, 1'b0, 32'h20, 32'h11223344);
        run_req("sb 0x21", 1'b1, 0, 1'b0, 32'h21, 32'h000000AB);
        check("sb waddr const", last_waddr, 32'h20);
        check("sb wdata const", last_wdata, 32'h1122AB44);
        run_req("lw 0x20", 1'b0, 2, 1'b0, 32'h20, 32'h0);
        check("lw 0x20 const", last_rdata, 32'h1122AB44);

        run_req("err sw 0x22", 1'b1, 2, 1'b0, 32'h22, 32'h5555_5555);
        run_req("err lh 0x03", 1'b0, 1, 1'b1, 32'h03, 32'h0);
        run_req("err size3", 1'b1, 3, 1'b0, 32'h04, 32'h1234_5678);
        run_req("err lw 0x400", 1'b0, 2, 1'b0, 32'h400, 32'h0);

        // Reset lands while the halfword merge is being written back.
        run_req("sw 0x40", 1'b1, 2, 1'b0, 32'h40, 32'h12345678);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_wr we before rst", {31'b0, bus.dmem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort dmem_we", {31'b0, bus.dmem_we}, 32'd0);
        check("abort resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("abort ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready after", {31'b0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort no resp", {31'b0, bus.resp_valid}, 32'd0);
        end
        check("abort mem16", mem[16], 32'h12345678);
        run_req("lw 0x40", 1'b0, 2, 1'b0, 32'h40, 32'h0);
        check("lw 0x40 const", last_rdata, 32'h12345678);

        // Back-to-back: req_valid stays high across SW then LW to the same word.
        w1 = $urandom;
        model_store(32'h80, 2, w1);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h80; bus.req_wdata = w1;
        @(posedge clk);
        first_resp = -1; acc_c = -1; second_resp = -1; rd2 = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_we = 1'b0;
                bus.req_wdata = 32'h0;
            end
            if (acc_c >= 0 && c == acc_c + 1) bus.req_valid = 1'b0;
            if (bus.resp_valid && first_resp < 0) first_resp = c;
            else if (bus.resp_valid && acc_c >= 0 && c > acc_c) begin
                second_resp = c;
                rd2 = bus.resp_rdata;
                break;
            end
            if (bus.req_ready && acc_c < 0) acc_c = c;
        end
        check("b2b first resp", first_resp, 32'd2);
        check("b2b accept cycle", acc_c, 32'd3);
        check("b2b second resp", second_resp, 32'd5);
        check("b2b rdata", rd2, w1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 255);
            sz = ($urandom_range(0, 14) == 0) ? 3 : $urandom_range(0, 2);
            run_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < 64; i++) check("final mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
